// File: rtl/fp_minmax_cmp_pipe_if.sv
// Operand/result bus for the FP min/max/compare unit.
// Both directions use valid/ready: a beat moves on a rising edge where valid & ready are
// both high; the source holds its payload stable until that edge, and ready may depend on valid.
interface fp_minmax_cmp_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         out_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_numA;
  logic [W-1:0] in_numB;
  logic         out_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_flag_nv;

  modport slave (
    input  in_valid, in_op, in_numA, in_numB, in_ready,
    output out_ready, out_valid, out_data, out_flag_nv
  );

  modport master (
    output in_valid, in_op, in_numA, in_numB, in_ready,
    input  out_ready, out_valid, out_data, out_flag_nv
  );
endinterface

// File: rtl/fp_minmax_cmp_pipe.sv
// Two-stage IEEE-754 MIN/MAX/FEQ/FLT/FLE unit with RISC-V NaN and signed-zero rules.
// Stage 1 captures operands, class bits and the magnitude compare; stage 2 registers the result.
module fp_minmax_cmp_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  fp_minmax_cmp_pipe_if.slave   bus
);
  localparam int W = 1 + EXP_W + MAN_W;

  localparam logic [2:0] OP_MIN = 3'd0;
  localparam logic [2:0] OP_MAX = 3'd1;
  localparam logic [2:0] OP_FEQ = 3'd2;
  localparam logic [2:0] OP_FLT = 3'd3;
  localparam logic [2:0] OP_FLE = 3'd4;

  localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Operand classification on the incoming operands
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic a_nan_c, a_snan_c, a_zero_c, b_nan_c, b_snan_c, b_zero_c;
  logic mag_lt_c, mag_gt_c;

  assign a_exp    = bus.in_numA[W-2:MAN_W];
  assign a_man    = bus.in_numA[MAN_W-1:0];
  assign b_exp    = bus.in_numB[W-2:MAN_W];
  assign b_man    = bus.in_numB[MAN_W-1:0];
  assign a_nan_c  = (&a_exp) & (|a_man);
  assign b_nan_c  = (&b_exp) & (|b_man);
  assign a_snan_c = a_nan_c & ~a_man[MAN_W-1];
  assign b_snan_c = b_nan_c & ~b_man[MAN_W-1];
  assign a_zero_c = ~(|bus.in_numA[W-2:0]);
  assign b_zero_c = ~(|bus.in_numB[W-2:0]);
  assign mag_lt_c = bus.in_numA[W-2:0] < bus.in_numB[W-2:0];
  assign mag_gt_c = bus.in_numA[W-2:0] > bus.in_numB[W-2:0];

  logic         s1_valid_q;
  logic [2:0]   s1_op_q;
  logic [W-1:0] s1_a_q, s1_b_q;
  logic         s1_a_nan_q, s1_a_snan_q, s1_a_zero_q;
  logic         s1_b_nan_q, s1_b_snan_q, s1_b_zero_q;
  logic         s1_mag_lt_q, s1_mag_gt_q;

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         out_flag_nv_q, out_flag_nv_d;

  logic s2_load, s1_load;

  // Output stage frees up when empty or draining; stage 1 follows it with no bubble
  assign s2_load = ~out_valid_q | bus.in_ready;
  assign s1_load = ~s1_valid_q | s2_load;

  assign bus.out_ready   = s1_load;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_flag_nv = out_flag_nv_q;

  // Result selection from stage-1 contents
  logic sa, sb, both_zero, any_nan, any_snan, lt_ab, lt_ba, eq_ab;
  logic min_pick_b, max_pick_b;

  always_comb begin
    sa        = s1_a_q[W-1];
    sb        = s1_b_q[W-1];
    both_zero = s1_a_zero_q & s1_b_zero_q;
    any_nan   = s1_a_nan_q | s1_b_nan_q;
    any_snan  = s1_a_snan_q | s1_b_snan_q;
    lt_ab     = 1'b0;
    lt_ba     = 1'b0;
    if (both_zero) begin
      lt_ab = 1'b0;
      lt_ba = 1'b0;
    end else if (sa != sb) begin
      lt_ab = sa;
      lt_ba = sb;
    end else if (!sa) begin
      lt_ab = s1_mag_lt_q;
      lt_ba = s1_mag_gt_q;
    end else begin
      lt_ab = s1_mag_gt_q;
      lt_ba = s1_mag_lt_q;
    end
    eq_ab      = both_zero | ((sa == sb) & ~s1_mag_lt_q & ~s1_mag_gt_q);
    // Signed zeros: MIN prefers -0, MAX prefers +0; otherwise ties keep A
    min_pick_b = both_zero ? (sb & ~sa) : lt_ba;
    max_pick_b = both_zero ? (sa & ~sb) : lt_ab;

    out_valid_d   = s1_valid_q;
    out_data_d    = '0;
    out_flag_nv_d = 1'b0;
    case (s1_op_q)
      OP_MIN, OP_MAX: begin
        out_flag_nv_d = any_snan;
        if (s1_a_nan_q & s1_b_nan_q)       out_data_d = CANON_NAN;
        else if (s1_a_nan_q)               out_data_d = s1_b_q;
        else if (s1_b_nan_q)               out_data_d = s1_a_q;
        else if (s1_op_q == OP_MIN)        out_data_d = min_pick_b ? s1_b_q : s1_a_q;
        else                               out_data_d = max_pick_b ? s1_b_q : s1_a_q;
      end
      OP_FEQ: begin
        out_flag_nv_d = any_snan;
        out_data_d    = {{(W-1){1'b0}}, eq_ab & ~any_nan};
      end
      OP_FLT: begin
        out_flag_nv_d = any_nan;
        out_data_d    = {{(W-1){1'b0}}, lt_ab & ~any_nan};
      end
      OP_FLE: begin
        out_flag_nv_d = any_nan;
        out_data_d    = {{(W-1){1'b0}}, (lt_ab | eq_ab) & ~any_nan};
      end
      default: begin
        out_data_d    = '0;
        out_flag_nv_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_a_nan_q  <= 1'b0;
      s1_a_snan_q <= 1'b0;
      s1_a_zero_q <= 1'b0;
      s1_b_nan_q  <= 1'b0;
      s1_b_snan_q <= 1'b0;
      s1_b_zero_q <= 1'b0;
      s1_mag_lt_q <= 1'b0;
      s1_mag_gt_q <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_op_q     <= bus.in_op;
        s1_a_q      <= bus.in_numA;
        s1_b_q      <= bus.in_numB;
        s1_a_nan_q  <= a_nan_c;
        s1_a_snan_q <= a_snan_c;
        s1_a_zero_q <= a_zero_c;
        s1_b_nan_q  <= b_nan_c;
        s1_b_snan_q <= b_snan_c;
        s1_b_zero_q <= b_zero_c;
        s1_mag_lt_q <= mag_lt_c;
        s1_mag_gt_q <= mag_gt_c;
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_flag_nv_q <= 1'b0;
    end else if (s2_load) begin
      out_valid_q <= out_valid_d;
      if (s1_valid_q) begin
        out_data_q    <= out_data_d;
        out_flag_nv_q <= out_flag_nv_d;
      end
    end
  end
endmodule

// File: tb/tb_fp_minmax_cmp_pipe.sv
// Directed bench for fp_minmax_cmp_pipe in single and double precision with a
// queue-based scoreboard popped by per-instance output monitors.
module tb_fp_minmax_cmp_pipe;
  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  logic [32:0] sp_exp_q[$];
  logic [64:0] dp_exp_q[$];

  logic        sp_hold_v = 1'b0;
  logic [31:0] sp_hold_d;
  logic        sp_hold_nv;
  logic        sp_stall_seen = 1'b0;

  fp_minmax_cmp_pipe_if #(.EXP_W(8),  .MAN_W(23)) sp_if ();
  fp_minmax_cmp_pipe_if #(.EXP_W(11), .MAN_W(52)) dp_if ();

  fp_minmax_cmp_pipe #(.EXP_W(8), .MAN_W(23)) u_sp (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .bus      (sp_if)
  );

  fp_minmax_cmp_pipe #(.EXP_W(11), .MAN_W(52)) u_dp (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .bus      (dp_if)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  // Drivers: enter and leave at posedge+1; ready is sampled at posedge+3
  task automatic sp_send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ed, input logic en);
    int budget = 0;
    sp_if.in_valid = 1'b1;
    sp_if.in_op    = op;
    sp_if.in_numA  = a;
    sp_if.in_numB  = b;
    #2;
    while (!sp_if.out_ready && budget < 50) begin
      @(posedge clk); #3;
      budget++;
    end
    if (budget >= 50) begin
      total++; bad++;
      $display("FAIL sp_accept_timeout op=%0d act=not_accepted req=accepted", op);
    end else begin
      sp_exp_q.push_back({en, ed});
    end
    @(posedge clk); #1;
    sp_if.in_valid = 1'b0;
  endtask

  task automatic dp_send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] ed, input logic en);
    int budget = 0;
    dp_if.in_valid = 1'b1;
    dp_if.in_op    = op;
    dp_if.in_numA  = a;
    dp_if.in_numB  = b;
    #2;
    while (!dp_if.out_ready && budget < 50) begin
      @(posedge clk); #3;
      budget++;
    end
    if (budget >= 50) begin
      total++; bad++;
      $display("FAIL dp_accept_timeout op=%0d act=not_accepted req=accepted", op);
    end else begin
      dp_exp_q.push_back({en, ed});
    end
    @(posedge clk); #1;
    dp_if.in_valid = 1'b0;
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst_n) begin
      sp_hold_v = 1'b0;
    end else begin
      if (sp_hold_v) begin
        chk("sp_stall_data", 64'(sp_if.out_data), 64'(sp_hold_d));
        chk("sp_stall_nv", 64'(sp_if.out_flag_nv), 64'(sp_hold_nv));
      end
      sp_hold_v  = sp_if.out_valid & ~sp_if.in_ready;
      sp_hold_d  = sp_if.out_data;
      sp_hold_nv = sp_if.out_flag_nv;
      if (sp_if.in_valid && !sp_if.out_ready) sp_stall_seen = 1'b1;
      if (sp_if.out_valid && sp_if.in_ready) begin
        if (sp_exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sp_unexpected act=%h req=no_result", sp_if.out_data);
        end else begin
          e = sp_exp_q.pop_front();
          chk("sp_data", 64'(sp_if.out_data), 64'(e[31:0]));
          chk("sp_nv", 64'(sp_if.out_flag_nv), 64'(e[32]));
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [64:0] e;
    if (rst_n && dp_if.out_valid && dp_if.in_ready) begin
      if (dp_exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL dp_unexpected act=%h req=no_result", dp_if.out_data);
      end else begin
        e = dp_exp_q.pop_front();
        chk("dp_data", dp_if.out_data, e[63:0]);
        chk("dp_nv", 64'(dp_if.out_flag_nv), 64'(e[64]));
      end
    end
  end

  initial begin
    int budget;
    rst_n          = 1'b0;
    sp_if.in_valid = 1'b0;
    sp_if.in_op    = '0;
    sp_if.in_numA  = '0;
    sp_if.in_numB  = '0;
    sp_if.in_ready = 1'b1;
    dp_if.in_valid = 1'b0;
    dp_if.in_op    = '0;
    dp_if.in_numA  = '0;
    dp_if.in_numB  = '0;
    dp_if.in_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(sp_if.out_valid), 64'd0);
    chk("rst_out_data", 64'(sp_if.out_data), 64'd0);
    chk("rst_out_nv", 64'(sp_if.out_flag_nv), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_ready", 64'(sp_if.out_ready), 64'd1);
    chk("rst_dp_out_valid", 64'(dp_if.out_valid), 64'd0);

    // Reset mid-op: the accepted MAX must never emerge
    sp_if.in_valid = 1'b1;
    sp_if.in_op    = 3'd1;
    sp_if.in_numA  = 32'h3F800000;
    sp_if.in_numB  = 32'h40000000;
    @(posedge clk); #1;
    sp_if.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(sp_if.out_valid), 64'd0);
    chk("midrst_out_data", 64'(sp_if.out_data), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_result", 64'(sp_if.out_valid), 64'd0);
    end

    // Single-precision MIN/MAX and signed zero
    sp_send(3'd0, 32'h3F800000, 32'hBF800000, 32'hBF800000, 1'b0);
    sp_send(3'd1, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0);
    sp_send(3'd0, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0);
    sp_send(3'd1, 32'h00000000, 32'h80000000, 32'h00000000, 1'b0);
    sp_send(3'd0, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0);
    sp_send(3'd1, 32'hC0000000, 32'hBF800000, 32'hBF800000, 1'b0);
    sp_send(3'd0, 32'hC0000000, 32'hBF800000, 32'hC0000000, 1'b0);
    // NaN handling
    sp_send(3'd1, 32'h7FC00000, 32'h40000000, 32'h40000000, 1'b0);
    sp_send(3'd0, 32'h40000000, 32'h7FC00000, 32'h40000000, 1'b0);
    sp_send(3'd0, 32'h7F800001, 32'h7F800001, 32'h7FC00000, 1'b1);
    sp_send(3'd2, 32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b0);
    sp_send(3'd2, 32'h7F800001, 32'h00000000, 32'h00000000, 1'b1);
    sp_send(3'd3, 32'h7FC00000, 32'h3F800000, 32'h00000000, 1'b1);
    // Compares
    sp_send(3'd4, 32'h80000000, 32'h00000000, 32'h00000001, 1'b0);
    sp_send(3'd3, 32'h80000000, 32'h00000000, 32'h00000000, 1'b0);
    sp_send(3'd2, 32'h80000000, 32'h00000000, 32'h00000001, 1'b0);
    sp_send(3'd3, 32'hFF800000, 32'hC0000000, 32'h00000001, 1'b0);
    sp_send(3'd4, 32'h40000000, 32'h40000000, 32'h00000001, 1'b0);
    sp_send(3'd3, 32'h40000000, 32'h3F800000, 32'h00000000, 1'b0);
    // Reserved op
    sp_send(3'd5, 32'h7F800001, 32'h3F800000, 32'h00000000, 1'b0);

    // Backpressure: 8 back-to-back MAX ops against 3.0 with a 3-cycle stall
    sp_stall_seen = 1'b0;
    fork
      for (int i = 0; i < 8; i++)
        sp_send(3'd1, 32'h3F800000 + (i << 23), 32'h40400000,
                (i < 2) ? 32'h40400000 : 32'h3F800000 + (i << 23), 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 sp_if.in_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 sp_if.in_ready = 1'b1;
      end
    join
    chk("sp_out_ready_drop", 64'(sp_stall_seen), 64'd1);

    // Double precision
    dp_send(3'd1, 64'hC000000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0);
    dp_send(3'd1, 64'h7FF8000000000000, 64'h7FF8000000000000, 64'h7FF8000000000000, 1'b0);
    dp_send(3'd0, 64'h3FF0000000000000, 64'hC000000000000000, 64'hC000000000000000, 1'b0);
    dp_send(3'd0, 64'h7FF0000000000001, 64'h7FF4000000000000, 64'h7FF8000000000000, 1'b1);
    dp_send(3'd3, 64'hC000000000000000, 64'h3FF0000000000000, 64'h0000000000000001, 1'b0);

    budget = 0;
    while ((sp_exp_q.size() != 0 || dp_exp_q.size() != 0) && budget < 100) begin
      @(posedge clk);
      budget++;
    end
    repeat (3) @(posedge clk);
    chk("sp_queue_drained", 64'(sp_exp_q.size()), 64'd0);
    chk("dp_queue_drained", 64'(dp_exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
